// File: rtl/mac_column_drain.sv
// Column drain: folds deferred error products into partial sums, accumulates num_tiles beats per
// result (saturating) and queues results in a small FIFO. Optional macro: MAC_DRAIN_ERRCNT_EN.
module mac_column_drain #(
    parameter int PSUM_W     = 24,
    parameter int ERR_W      = 16,
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_tiles,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic [ERR_W-1:0]   err_prod_in,
    input  logic               err_valid_in,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [15:0]        err_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ACC_W + 2;
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, WRITE = 2'd2} state_t;

    state_t              state_r, state_s;
    logic [ACC_W-1:0]    acc_r, acc_next_s, head_s, out_data_r;
    logic [CNT_W-1:0]    remain_r;
    logic [ACC_W-1:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [AW:0]         count_r, count_next_s;
    logic                in_ready_r, busy_r, out_valid_r;
    logic                beat_s, push_s, pop_s, full_s, job_start_s;
    logic [SUM_W-1:0]    sum_s;

    assign beat_s = in_valid && (state_r == ACCUM);
    assign full_s = (count_r == DEPTH_C);
    assign pop_s  = out_valid_r && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state and job/push strobes
    always_comb begin
        state_s     = state_r;
        job_start_s = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (num_tiles != {CNT_W{1'b0}})) begin
                    state_s     = ACCUM;
                    job_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && (remain_r == CNT_ONE)) state_s = WRITE;
                else                                 state_s = ACCUM;
            end
            WRITE: begin
                // a same-cycle pop frees the slot even when full
                if (!full_s || out_ready) begin
                    push_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WRITE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Saturating beat accumulation with the deferred error product folded in
    always_comb begin
        sum_s = {2'b00, acc_r} + {{(SUM_W-PSUM_W){1'b0}}, psum_in};
        if (err_valid_in) sum_s = sum_s + {{(SUM_W-ERR_W){1'b0}}, err_prod_in};
        else              sum_s = sum_s;
        if (sum_s > {2'b00, ACC_MAX}) acc_next_s = ACC_MAX;
        else                          acc_next_s = sum_s[ACC_W-1:0];
    end

    // Accumulator and remaining-tile counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            remain_r <= {CNT_W{1'b0}};
        end else if (job_start_s) begin
            acc_r    <= {ACC_W{1'b0}};
            remain_r <= num_tiles;
        end else if (beat_s) begin
            acc_r    <= acc_next_s;
            remain_r <= remain_r - CNT_ONE;
        end
    end

    // FIFO bookkeeping and the next head word
    always_comb begin
        count_next_s  = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        if (push_s && (count_r == {{AW{1'b0}}, pop_s})) head_s = acc_r;
        else                                             head_s = mem_r[rd_ptr_next_s];
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= acc_r;
    end

    // FIFO pointers and registered outputs; out_data keeps its last value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != {(AW+1){1'b0}});
            if (count_next_s != {(AW+1){1'b0}}) out_data_r <= head_s;
            in_ready_r  <= (state_s == ACCUM);
            busy_r      <= (state_s != IDLE);
        end
    end

`ifdef MAC_DRAIN_ERRCNT_EN
    logic [15:0] err_cnt_r;

    // Count beats carrying an uncommitted error product, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        err_cnt_r <= 16'h0000;
        else if (job_start_s)                              err_cnt_r <= 16'h0000;
        else if (beat_s && err_valid_in && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'h0001;
    end
    assign err_count = err_cnt_r;
`else
    assign err_count = 16'h0000;
`endif

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
endmodule

// File: tb/tb_mac_column_drain.sv
// Directed bench for mac_column_drain: default instance plus an ACC_W=24 instance sharing stimulus.
module tb_mac_column_drain;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, err_valid_in, out_ready;
    logic [7:0]  num_tiles;
    logic [23:0] psum_in;
    logic [15:0] err_prod_in;
    logic        in_ready, out_valid, busy, s_in_ready, s_out_valid, s_busy;
    logic [31:0] out_data;
    logic [23:0] s_out_data;
    logic [15:0] err_count, s_err_count;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_column_drain u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
        .err_prod_in(err_prod_in), .err_valid_in(err_valid_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_count(err_count)
    );

    mac_column_drain #(.ACC_W(24)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .in_valid(in_valid), .in_ready(s_in_ready), .psum_in(psum_in),
        .err_prod_in(err_prod_in), .err_valid_in(err_valid_in),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .busy(s_busy), .err_count(s_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1; num_tiles = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [23:0] p, input logic [15:0] e, input logic ev);
        in_valid = 1'b1; psum_in = p; err_prod_in = e; err_valid_in = ev;
        tick();
        in_valid = 1'b0; err_valid_in = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; num_tiles = 8'd0; in_valid = 1'b0;
        psum_in = 24'd0; err_prod_in = 16'd0; err_valid_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single tile, two-edge latency
        start_job(8'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        beat(24'h008000, 16'h0000, 1'b0);
        chk("t1_write_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_data", out_data, 32'h0000_8000);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        pop_one();
        chk("t1_empty", {31'd0, out_valid}, 32'd0);
        chk("t1_hold_data", out_data, 32'h0000_8000);

        // 2: three tiles with error folding and a bubble
        start_job(8'd3);
        beat(24'h004000, 16'h0012, 1'b1);
        tick();
        beat(24'h008000, 16'h0000, 1'b0);
        beat(24'h001000, 16'h0020, 1'b1);
        tick();
        chk("t2_out_data", out_data, 32'h0000_D032);
        chk("t2_sat_inst", {8'd0, s_out_data}, 32'h0000_D032);
`ifdef MAC_DRAIN_ERRCNT_EN
        chk("t2_err_count", {16'd0, err_count}, 32'd2);
`else
        chk("t2_err_count", {16'd0, err_count}, 32'd0);
`endif
        pop_one();

        // 3: fill FIFO, fifth job stalls in WRITE, then drain in order
        for (int i = 1; i <= 5; i++) begin
            start_job(8'd1);
            beat(24'(i), 16'h0000, 1'b0);
            tick();
        end
        chk("t3_stall_busy", {31'd0, busy}, 32'd1);
        chk("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t3_still_busy", {31'd0, busy}, 32'd1);
        chk("t3_head", out_data, 32'd1);
        out_ready = 1'b1;
        start = 1'b1; num_tiles = 8'd1;
        tick();
        start = 1'b0;
        chk("t3_write_done", {31'd0, busy}, 32'd0);
        chk("t3_drain_2", out_data, 32'd2);
        tick();
        chk("t3_start_ignored", {31'd0, busy}, 32'd0);
        chk("t3_drain_3", out_data, 32'd3);
        tick();
        chk("t3_drain_4", out_data, 32'd4);
        tick();
        chk("t3_drain_5", out_data, 32'd5);
        chk("t3_valid_5", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t3_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // 4: saturation on the 24-bit accumulator instance
        start_job(8'd2);
        beat(24'hFFFFFF, 16'h0000, 1'b0);
        beat(24'hFFFFFF, 16'h0000, 1'b0);
        tick();
        chk("t4_sat24", {8'd0, s_out_data}, 32'h00FF_FFFF);
        chk("t4_wide32", out_data, 32'h01FF_FFFE);
        pop_one();

        // 5: zero-tile start, and start during ACCUM
        start_job(8'd0);
        chk("t5_zero_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_zero_no_valid", {31'd0, out_valid}, 32'd0);
        start_job(8'd2);
        beat(24'h000005, 16'h0000, 1'b0);
        start_job(8'd7);
        beat(24'h000006, 16'h0000, 1'b0);
        tick();
        chk("t5_midaccum_data", out_data, 32'h0000_000B);
        chk("t5_midaccum_idle", {31'd0, busy}, 32'd0);
        pop_one();

        // 6: async reset mid-ACCUM with two results queued
        for (int i = 7; i <= 8; i++) begin
            start_job(8'd1);
            beat(24'(i), 16'h0000, 1'b0);
            tick();
        end
        start_job(8'd2);
        beat(24'h000009, 16'h0000, 1'b0);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        chk("t6_async_data", out_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_post_in_ready", {31'd0, in_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
